baud_tick_gen_prog: RTL and testbench

//   Runtime-programmable fractional baud tick generator for the serial path (UART TX/RX to Raspberry Pi).

---
 rtl/baud_tick_gen_prog_if.sv | 29 ++
 rtl/baud_tick_gen_prog.sv | 56 +++++
 tb/tb_baud_tick_gen_prog.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_gen_prog_if.sv
// Control and status bundle for the programmable baud tick generator.
// The master drives run/resync/increment controls; the slave returns the active
// increment and the tick strobes.
interface baud_tick_gen_prog_if #(
    parameter int ACC_WIDTH    = 16,
    parameter int OVERSAMPLING = 16
);
    localparam int PH_W = $clog2(OVERSAMPLING);

    logic                 enable;
    logic                 resync;
    logic                 inc_load;
    logic [ACC_WIDTH-1:0] inc_in;
    logic [ACC_WIDTH-1:0] inc_q;
    logic                 tick;
    logic                 bit_tick;
    logic                 mid_tick;
    logic [PH_W-1:0]      os_phase;

    modport master (
        output enable, resync, inc_load, inc_in,
        input  inc_q, tick, bit_tick, mid_tick, os_phase
    );

    modport slave (
        input  enable, resync, inc_load, inc_in,
        output inc_q, tick, bit_tick, mid_tick, os_phase
    );
endinterface

// File: rtl/baud_tick_gen_prog.sv
// Runtime-programmable fractional baud tick generator.
// A phase accumulator produces oversample ticks from its carry bit; a small
// counter over those ticks gives per-bit and mid-bit strobes. The increment can
// be reloaded at runtime, and the phase can be restarted to align RX sampling.
module baud_tick_gen_prog #(
    parameter int ACC_WIDTH    = 16,
    parameter int OVERSAMPLING = 16,
    parameter int DEFAULT_INC  = 2416
) (
    input  logic                  clk,
    input  logic                  rst,
    baud_tick_gen_prog_if.slave   bus
);
    localparam int                  W       = ACC_WIDTH;
    localparam int                  PH_W    = $clog2(OVERSAMPLING);
    localparam logic [PH_W-1:0]     OS_LAST = PH_W'(OVERSAMPLING - 1);
    localparam logic [PH_W-1:0]     OS_MID  = PH_W'(OVERSAMPLING / 2 - 1);
    localparam logic [W-1:0]        INC_RST = W'(DEFAULT_INC);

    logic [W:0]      acc;     // bit W is the carry of the last addition
    logic [PH_W-1:0] os_cnt;  // ticks already seen in the current bit
    logic [W-1:0]    inc_q;

    // Phase accumulator and in-bit tick counter; cleared by reset, resync or disable.
    // NOTE: registered state is always assigned with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            os_cnt <= '0;
        end else if (bus.resync || !bus.enable) begin
            acc    <= '0;
            os_cnt <= '0;
        end else begin
            acc <= {1'b0, acc[W-1:0]} + {1'b0, inc_q};
            if (acc[W]) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            end
        end
    end

    // Active increment: reloadable at any time except reset; zero is rejected so ticks never stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_q <= INC_RST;
        end else if (bus.inc_load && (bus.inc_in != '0)) begin
            inc_q <= bus.inc_in;
        end
    end

    // Strobes come straight from registers, so there is no path from inputs to tick.
    assign bus.tick     = acc[W];
    assign bus.bit_tick = acc[W] && (os_cnt == OS_LAST);
    assign bus.mid_tick = acc[W] && (os_cnt == OS_MID);
    assign bus.os_phase = os_cnt;
    assign bus.inc_q    = inc_q;
endmodule

// File: tb/tb_baud_tick_gen_prog.sv
// Self-checking bench for baud_tick_gen_prog: directed scenarios plus a random
// phase, with a per-cycle scoreboard fed by an arithmetic reference model.
module tb_baud_tick_gen_prog;
    localparam int W    = 16;
    localparam int OS   = 16;
    localparam int DEF  = 2416;
    localparam int PH_W = $clog2(OS);
    localparam longint MODULUS = 64'd1 << W;

    typedef struct {
        logic            tick;
        logic            bit_t;
        logic            mid_t;
        logic [PH_W-1:0] ph;
        logic [W-1:0]    inc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    baud_tick_gen_prog_if #(.ACC_WIDTH(W), .OVERSAMPLING(OS)) bif ();

    baud_tick_gen_prog #(.ACC_WIDTH(W), .OVERSAMPLING(OS), .DEFAULT_INC(DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        else n_pass++;
    endtask

    // Reference model: total phase as an unbounded integer; a tick is a change
    // of its integer part; os phase is the number of earlier ticks modulo OS.
    longint m_total;
    bit     m_tick;
    int     m_seen;
    int     m_inc;
    exp_t   exp_q[$];

    task automatic model_edge(input bit r, input bit rs, input bit en, input bit ld, input int din);
        longint q_old;
        if (r) begin
            m_total = 0; m_tick = 0; m_seen = 0; m_inc = DEF;
        end else begin
            if (rs || !en) begin
                m_total = 0; m_tick = 0; m_seen = 0;
            end else begin
                if (m_tick) m_seen = (m_seen + 1) % OS;
                q_old   = m_total / MODULUS;
                m_total = m_total + m_inc;
                m_tick  = (m_total / MODULUS) != q_old;
            end
            if (ld && din != 0) m_inc = din;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.tick  = m_tick;
        e.bit_t = m_tick && (m_seen == OS - 1);
        e.mid_t = m_tick && (m_seen == OS / 2 - 1);
        e.ph    = PH_W'(m_seen);
        e.inc   = W'(m_inc);
        exp_q.push_back(e);
    endtask

    // Monitor statistics, observed from the DUT outputs.
    int st_cyc, n_tick, n_bit, n_mid;
    int first_tick, first_bit, first_mid, last_tick, min_int, max_int;

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        settle();
        st_cyc = 0; n_tick = 0; n_bit = 0; n_mid = 0;
        first_tick = -1; first_bit = -1; first_mid = -1; last_tick = -1;
        min_int = 1 << 30; max_int = 0;
    endtask

    // Scoreboard monitor: one expected record per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs{tick,bit,mid,phase,inc}",
                  {bif.tick, bif.bit_tick, bif.mid_tick, bif.os_phase, bif.inc_q},
                  {e.tick, e.bit_t, e.mid_t, e.ph, e.inc});
            st_cyc++;
            if (bif.tick) begin
                n_tick++;
                if (first_tick < 0) first_tick = st_cyc;
                if (last_tick >= 0) begin
                    if (st_cyc - last_tick < min_int) min_int = st_cyc - last_tick;
                    if (st_cyc - last_tick > max_int) max_int = st_cyc - last_tick;
                end
                last_tick = st_cyc;
            end
            if (bif.bit_tick) begin
                n_bit++;
                if (first_bit < 0) first_bit = st_cyc;
            end
            if (bif.mid_tick) begin
                n_mid++;
                if (first_mid < 0) first_mid = st_cyc;
            end
        end
    end

    // One clock edge of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic step(input bit r, input bit rs, input bit en, input bit ld, input int din);
        rst          = r;
        bif.resync   = rs;
        bif.enable   = en;
        bif.inc_load = ld;
        bif.inc_in   = W'(din);
        @(posedge clk);
        model_edge(r, rs, en, ld, din);
        push_expected();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; bif.resync = 0; bif.enable = 0; bif.inc_load = 0; bif.inc_in = '0;
        clear_stats();

        // Default increment over one full accumulator period.
        step(1, 0, 0, 0, 0);
        check("reset_tick", bif.tick, 0);
        check("reset_phase", bif.os_phase, 0);
        check("reset_inc", bif.inc_q, DEF);
        clear_stats();
        run(65536);
        settle();
        check("t1_ticks", n_tick, 2416);
        check("t1_bit_ticks", n_bit, 151);
        check("t1_min_interval", min_int, 27);
        check("t1_max_interval", max_int, 28);
        check("t1_first_tick", first_tick, 28);

        // Half-rate increment.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32768);
        clear_stats();
        run(64);
        settle();
        check("t2_ticks", n_tick, 32);
        check("t2_first_tick", first_tick, 2);
        check("t2_first_mid", first_mid, 16);
        check("t2_first_bit", first_bit, 32);
        check("t2_bit_count", n_bit, 2);
        check("t2_mid_count", n_mid, 2);

        // Maximum increment; a zero load must be ignored.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 65535);
        step(0, 0, 0, 1, 0);
        check("t3_inc_held", bif.inc_q, 65535);
        clear_stats();
        run(4096);
        settle();
        check("t3_ticks", n_tick, 4095);
        check("t3_min_interval", min_int, 1);
        check("t3_max_interval", max_int, 1);

        // Resync at phase 5.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32768);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 0, 1, 0, 0);
            if (bif.os_phase == 5) found = 1;
        end
        check("t4_reached_phase5", found, 1);
        clear_stats();
        step(0, 1, 1, 0, 0);
        check("t4_tick_after_resync", bif.tick, 0);
        check("t4_phase_after_resync", bif.os_phase, 0);
        run(40);
        settle();
        check("t4_first_tick", first_tick, 3);
        check("t4_first_bit", first_bit, 33);

        // Disable mid-bit, reload while idle, re-enable.
        step(0, 0, 0, 0, 0);
        check("t5_tick_low", bif.tick, 0);
        check("t5_phase_low", bif.os_phase, 0);
        clear_stats();
        step(0, 0, 0, 1, 4096);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        settle();
        check("t5_strobes_while_low", n_tick + n_bit + n_mid, 0);
        check("t5_inc_loaded", bif.inc_q, 4096);
        clear_stats();
        run(20);
        settle();
        check("t5_first_tick", first_tick, 16);

        // Reset beats a simultaneous load and resync.
        step(1, 1, 1, 1, 100);
        check("t6_inc", bif.inc_q, DEF);
        check("t6_phase", bif.os_phase, 0);
        check("t6_tick", bif.tick, 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit r, rs, en, ld;
            int din;
            r  = ($urandom_range(0, 499) == 0);
            rs = ($urandom_range(0, 63) == 0);
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 2))
                0:       din = 0;
                1:       din = $urandom_range(1, 4096);
                default: din = $urandom_range(1, 65535);
            endcase
            step(r, rs, en, ld, din);
        end

        settle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
